// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles 32-bit words from four byte reads and hands them to decode.
// Optional direct-mapped word cache is compiled in with `define ICACHE_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_rd_en,
    output logic [31:0] mem_a,
    output logic        hit,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    typedef enum logic [1:0] {ISSUE, DRAIN, COMPLETE} state_t;

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  issue_cnt_q, issue_cnt_d;
    logic [1:0]  rcv_cnt_q, rcv_cnt_d;
    logic        rcv_vld_q, rcv_vld_d;
    logic [31:0] buf_q, buf_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        hit_q, hit_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    logic        last_byte;
    logic        do_present;
    logic [31:0] present_word;
    logic        reissue;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_vld;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic                    lookup_hit;
    logic                    fill_en;

    assign idx        = fetch_pc_q[IDX_W+1:2];
    assign tag        = fetch_pc_q[31:IDX_W+2];
    assign lookup_hit = line_vld[idx] && (line_tag[idx] == tag);
    assign fill_en    = (state_q == DRAIN) && last_byte && !jump_en;
    // With the cache, new addresses go through a one-cycle lookup before any memory request.
    assign reissue    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst)
            line_vld <= '0;
        else if (rdy && fill_en)
            line_vld[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= buf_d;
        end
    end
`else
    assign reissue    = 1'b1;
`endif

    assign last_byte = rcv_vld_q && (rcv_cnt_q == 2'd3);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        rcv_vld_d    = mem_rd_en_q && mem_grant;
        buf_d        = buf_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_a_d      = mem_a_q;
        hit_d        = 1'b0;
        pc_d         = pc_q;
        inst_d       = inst_q;
        do_present   = 1'b0;
        present_word = buf_q;

        // Bytes return in issue order, so a separate receive count places each one.
        if (rcv_vld_q) begin
            buf_d[{rcv_cnt_q, 3'b000} +: 8] = mem_din;
            rcv_cnt_d = rcv_cnt_q + 2'd1;
        end

        case (state_q)
            ISSUE: begin
                if (!mem_rd_en_q) begin
`ifdef ICACHE_EN
                    if (lookup_hit) begin
                        if (!stall) begin
                            do_present   = 1'b1;
                            present_word = line_data[idx];
                        end
                    end else begin
                        mem_a_d     = fetch_pc_q;
                        mem_rd_en_d = 1'b1;
                    end
`else
                    mem_a_d     = fetch_pc_q + {30'd0, issue_cnt_q};
                    mem_rd_en_d = 1'b1;
`endif
                end else if (mem_grant) begin
                    issue_cnt_d = issue_cnt_q + 2'd1;
                    if (issue_cnt_q == 2'd3) begin
                        mem_rd_en_d = 1'b0;
                        state_d     = DRAIN;
                    end else begin
                        mem_a_d = fetch_pc_q + {30'd0, issue_cnt_q} + 32'd1;
                    end
                end
            end
            DRAIN: begin
                if (last_byte) begin
                    if (!stall) begin
                        do_present   = 1'b1;
                        present_word = buf_d;
                    end else begin
                        state_d = COMPLETE;
                    end
                end
            end
            COMPLETE: begin
                if (!stall) begin
                    do_present   = 1'b1;
                    present_word = buf_q;
                end
            end
            default: state_d = ISSUE;
        endcase

        // Hand the word over and start the next fetch on the same edge.
        if (do_present) begin
            hit_d       = 1'b1;
            pc_d        = fetch_pc_q;
            inst_d      = present_word;
            fetch_pc_d  = fetch_pc_q + 32'd4;
            issue_cnt_d = 2'd0;
            rcv_cnt_d   = 2'd0;
            state_d     = ISSUE;
            mem_a_d     = fetch_pc_q + 32'd4;
            mem_rd_en_d = reissue;
        end

        // Redirect wins over everything; bytes from the aborted reads are dropped via rcv_vld.
        if (jump_en) begin
            fetch_pc_d  = jump_addr & ~32'd3;
            issue_cnt_d = 2'd0;
            rcv_cnt_d   = 2'd0;
            rcv_vld_d   = 1'b0;
            hit_d       = 1'b0;
            pc_d        = pc_q;
            inst_d      = inst_q;
            state_d     = ISSUE;
            mem_a_d     = jump_addr & ~32'd3;
            mem_rd_en_d = reissue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISSUE;
            fetch_pc_q  <= RESET_PC;
            issue_cnt_q <= 2'd0;
            rcv_cnt_q   <= 2'd0;
            rcv_vld_q   <= 1'b0;
            buf_q       <= 32'd0;
            mem_rd_en_q <= 1'b0;
            mem_a_q     <= 32'd0;
            hit_q       <= 1'b0;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0000_0013;
        end else if (rdy) begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            rcv_vld_q   <= rcv_vld_d;
            buf_q       <= buf_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_a_q     <= mem_a_d;
            hit_q       <= hit_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_a     = mem_a_q;
    assign hit       = hit_q;
    assign pc        = pc_q;
    assign inst      = inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte-wide memory model plus cycle-numbered checks (C0 = first cycle after reset).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, rdy, stall, jump_en, mem_grant;
    logic [31:0] jump_addr;
    logic [7:0]  mem_din;
    logic        mem_rd_en, hit;
    logic [31:0] mem_a, pc, inst;

    logic [7:0]  mem [0:511];
    int          cyc;
    int          n_pass = 0;
    int          n_fail = 0;

    inst_fetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_grant(mem_grant), .mem_din(mem_din),
        .mem_rd_en(mem_rd_en), .mem_a(mem_a),
        .hit(hit), .pc(pc), .inst(inst)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after an accepted read and is frozen by rdy like the rest of the core.
    always @(posedge clk)
        if (rdy && mem_rd_en && mem_grant) mem_din <= mem[mem_a[8:0]];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; stall = 1'b0; jump_en = 1'b0;
        jump_addr = 32'd0; mem_grant = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " hit"}, {31'd0, hit}, 32'd0);
        chk({tag, " pc"}, pc, 32'd0);
        chk({tag, " inst"}, inst, 32'h0000_0013);
        chk({tag, " rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, " mem_a"}, mem_a, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'ha0; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;
        mem[9'h100] = 8'h78; mem[9'h101] = 8'h56; mem[9'h102] = 8'h34; mem[9'h103] = 8'h12;
        mem[9'h1fc] = 8'hef; mem[9'h1fd] = 8'hbe; mem[9'h1fe] = 8'had; mem[9'h1ff] = 8'hde;
        mem_din = 8'h00;

`ifdef ICACHE_EN
        // Loop back to 0 after the pc=4 hit; the second pass is served from the cache.
        do_reset();
        chk_reset("c6 reset");
        go(6);  chk("c6 hit C6", {31'd0, hit}, 32'd1); chk("c6 pc C6", pc, 32'd0);
        go(12); chk("c6 hit C12", {31'd0, hit}, 32'd1); chk("c6 pc C12", pc, 32'd4);
        jump_en = 1'b1; jump_addr = 32'd0;
        tick();
        jump_en = 1'b0;
        chk("c6 rd_en C13", {31'd0, mem_rd_en}, 32'd0);
        chk("c6 hit C13", {31'd0, hit}, 32'd0);
        go(14);
        chk("c6 hit C14", {31'd0, hit}, 32'd1);
        chk("c6 pc C14", pc, 32'd0);
        chk("c6 inst C14", inst, 32'h00a0_0513);
        chk("c6 rd_en C14", {31'd0, mem_rd_en}, 32'd0);
        go(15);
        chk("c6 hit C15", {31'd0, hit}, 32'd1);
        chk("c6 pc C15", pc, 32'd4);
        chk("c6 inst C15", inst, 32'h0010_0593);
        chk("c6 rd_en C15", {31'd0, mem_rd_en}, 32'd0);
`else
        // 1: plain fetch of two words
        do_reset();
        chk_reset("t1 reset");
        go(1);  chk("t1 mem_a C1", mem_a, 32'd0); chk("t1 rd_en C1", {31'd0, mem_rd_en}, 32'd1);
        go(4);  chk("t1 mem_a C4", mem_a, 32'd3);
        go(5);  chk("t1 rd_en C5", {31'd0, mem_rd_en}, 32'd0); chk("t1 hit C5", {31'd0, hit}, 32'd0);
        go(6);
        chk("t1 hit C6", {31'd0, hit}, 32'd1);
        chk("t1 pc C6", pc, 32'd0);
        chk("t1 inst C6", inst, 32'h00a0_0513);
        chk("t1 mem_a C6", mem_a, 32'd4);
        go(7);  chk("t1 hit C7", {31'd0, hit}, 32'd0);
        go(10); chk("t1 hit C10", {31'd0, hit}, 32'd0);
        go(11);
        chk("t1 hit C11", {31'd0, hit}, 32'd1);
        chk("t1 pc C11", pc, 32'd4);
        chk("t1 inst C11", inst, 32'h0010_0593);

        // 2: redirect mid-fetch (reset here also lands mid-fetch)
        do_reset();
        chk_reset("t2 reset");
        go(3);
        jump_en = 1'b1; jump_addr = 32'h0000_0103;
        tick();
        jump_en = 1'b0;
        chk("t2 mem_a C4", mem_a, 32'h100);
        chk("t2 rd_en C4", {31'd0, mem_rd_en}, 32'd1);
        chk("t2 hit C4", {31'd0, hit}, 32'd0);
        go(6);  chk("t2 hit C6", {31'd0, hit}, 32'd0);
        go(8);  chk("t2 hit C8", {31'd0, hit}, 32'd0);
        go(9);
        chk("t2 hit C9", {31'd0, hit}, 32'd1);
        chk("t2 pc C9", pc, 32'h100);
        chk("t2 inst C9", inst, 32'h1234_5678);

        // 3: stall holds the finished word; stall is sampled at the edge closing each
        //    cycle, so releasing it during C9 lets the word out in C10
        do_reset();
        go(4);  stall = 1'b1;
        go(5);  chk("t3 rd_en C5", {31'd0, mem_rd_en}, 32'd0);
        go(6);  chk("t3 hit C6", {31'd0, hit}, 32'd0);
        go(7);  chk("t3 rd_en C7", {31'd0, mem_rd_en}, 32'd0);
        go(9);
        chk("t3 hit C9", {31'd0, hit}, 32'd0);
        chk("t3 rd_en C9", {31'd0, mem_rd_en}, 32'd0);
        stall = 1'b0;
        go(10);
        chk("t3 hit C10", {31'd0, hit}, 32'd1);
        chk("t3 pc C10", pc, 32'd0);
        chk("t3 inst C10", inst, 32'h00a0_0513);
        chk("t3 mem_a C10", mem_a, 32'd4);
        chk("t3 rd_en C10", {31'd0, mem_rd_en}, 32'd1);

        // 4: arbitration loss in C2..C3
        do_reset();
        go(2);  mem_grant = 1'b0; chk("t4 mem_a C2", mem_a, 32'd1);
        go(3);  chk("t4 mem_a C3", mem_a, 32'd1); chk("t4 rd_en C3", {31'd0, mem_rd_en}, 32'd1);
        go(4);  mem_grant = 1'b1; chk("t4 mem_a C4", mem_a, 32'd1);
        go(5);  chk("t4 mem_a C5", mem_a, 32'd2);
        go(7);  chk("t4 hit C7", {31'd0, hit}, 32'd0);
        go(8);
        chk("t4 hit C8", {31'd0, hit}, 32'd1);
        chk("t4 pc C8", pc, 32'd0);
        chk("t4 inst C8", inst, 32'h00a0_0513);

        // 5: rdy freeze in C3..C4, then again across a hit cycle
        do_reset();
        go(2);  chk("t5 mem_a C2", mem_a, 32'd1);
        go(3);  rdy = 1'b0; chk("t5 mem_a C3", mem_a, 32'd2);
        go(4);  chk("t5 mem_a C4", mem_a, 32'd2); chk("t5 rd_en C4", {31'd0, mem_rd_en}, 32'd1);
        go(5);  rdy = 1'b1; chk("t5 mem_a C5", mem_a, 32'd2);
        go(6);  chk("t5 mem_a C6", mem_a, 32'd3);
        go(7);  chk("t5 hit C7", {31'd0, hit}, 32'd0);
        go(8);
        chk("t5 hit C8", {31'd0, hit}, 32'd1);
        chk("t5 pc C8", pc, 32'd0);
        chk("t5 inst C8", inst, 32'h00a0_0513);
        rdy = 1'b0;
        go(9);
        chk("t5 hit held C9", {31'd0, hit}, 32'd1);
        chk("t5 mem_a held C9", mem_a, 32'd4);
        rdy = 1'b1;
        go(10);
        chk("t5 hit C10", {31'd0, hit}, 32'd0);
        chk("t5 mem_a C10", mem_a, 32'd5);

        // 7: unaligned redirect to the top of the address space; next fetch wraps to 0
        do_reset();
        jump_en = 1'b1; jump_addr = 32'hffff_ffff;
        tick();
        jump_en = 1'b0;
        chk("t7 mem_a C1", mem_a, 32'hffff_fffc);
        chk("t7 rd_en C1", {31'd0, mem_rd_en}, 32'd1);
        go(6);
        chk("t7 hit C6", {31'd0, hit}, 32'd1);
        chk("t7 pc C6", pc, 32'hffff_fffc);
        chk("t7 inst C6", inst, 32'hdead_beef);
        chk("t7 mem_a wrap C6", mem_a, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
